// File: rtl/altitude_integrator.sv
// -----------------------------------------------------------------------------
// altitude_integrator
//   Integrates per-second velocity samples over a burn with the trapezoidal
//   rule. Each accepted sample adds (v_prev + v_cur) to an ALT_W-bit
//   accumulator, so altitude is acc/2, truncated toward zero. Also reports the
//   number of samples taken and the peak sample. The accumulator saturates at
//   all-ones and raises a sticky overflow flag for the rest of the run.
//
// Ports
//   clk           in   1         clock
//   resetb        in   1         asynchronous active-low reset
//   start         in   1         arms a new integration (ignored while busy)
//   burntime      in   TIME_W    samples to integrate, latched on accepted start
//   velocity      in   VEL_W     current velocity sample
//   vel_valid     in   1         velocity carries a new sample this cycle
//   altitude      out  ALT_W-1   accumulator >> 1
//   elapsed       out  TIME_W    samples accepted since start
//   max_velocity  out  VEL_W     peak sample since start
//   busy          out  1         integration in progress
//   done          out  1         result valid, held until next accepted start
//   overflow      out  1         accumulator saturated during this run
// -----------------------------------------------------------------------------
module altitude_integrator #(
   parameter int unsigned VEL_W  = 128,
   parameter int unsigned TIME_W = 64,
   parameter int unsigned ALT_W  = 136
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              start,
   input  logic [TIME_W-1:0] burntime,
   input  logic [VEL_W-1:0]  velocity,
   input  logic              vel_valid,
   output logic [ALT_W-2:0]  altitude,
   output logic [TIME_W-1:0] elapsed,
   output logic [VEL_W-1:0]  max_velocity,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   // Two velocity terms must fit in the accumulator for the single-carry
   // saturation check below to be exact.
   localparam int unsigned ExtW = ALT_W + 1 - VEL_W;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e            r_state,   w_state_nxt;
   logic [ALT_W-1:0]  r_acc,     w_acc_nxt;
   logic [VEL_W-1:0]  r_vprev,   w_vprev_nxt;
   logic [TIME_W-1:0] r_elapsed, w_elapsed_nxt;
   logic [VEL_W-1:0]  r_max,     w_max_nxt;
   logic [TIME_W-1:0] r_bt,      w_bt_nxt;
   logic              r_ovf,     w_ovf_nxt;

   logic [ALT_W:0]    w_sum;
   logic [TIME_W-1:0] w_elapsed_inc;

   // Sum formed one bit wider than the accumulator; the top bit is the
   // saturation indicator.
   assign w_sum = {1'b0, r_acc}
                + {{ExtW{1'b0}}, r_vprev}
                + {{ExtW{1'b0}}, velocity};

   assign w_elapsed_inc = r_elapsed + {{(TIME_W-1){1'b0}}, 1'b1};

   always_comb begin
      w_state_nxt   = r_state;
      w_acc_nxt     = r_acc;
      w_vprev_nxt   = r_vprev;
      w_elapsed_nxt = r_elapsed;
      w_max_nxt     = r_max;
      w_bt_nxt      = r_bt;
      w_ovf_nxt     = r_ovf;

      unique case (r_state)
         StIdle, StDone: begin
            // A sample arriving alongside start is dropped.
            if (start) begin
               w_acc_nxt     = '0;
               w_vprev_nxt   = '0;
               w_elapsed_nxt = '0;
               w_max_nxt     = '0;
               w_ovf_nxt     = 1'b0;
               w_bt_nxt      = burntime;
               w_state_nxt   = (burntime == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (vel_valid) begin
               if (w_sum[ALT_W]) begin
                  w_acc_nxt = '1;
                  w_ovf_nxt = 1'b1;
               end else begin
                  w_acc_nxt = w_sum[ALT_W-1:0];
               end
               w_vprev_nxt   = velocity;
               w_elapsed_nxt = w_elapsed_inc;
               if (velocity > r_max) begin
                  w_max_nxt = velocity;
               end
               if (w_elapsed_inc == r_bt) begin
                  w_state_nxt = StDone;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state   <= StIdle;
         r_acc     <= '0;
         r_vprev   <= '0;
         r_elapsed <= '0;
         r_max     <= '0;
         r_bt      <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_vprev   <= w_vprev_nxt;
         r_elapsed <= w_elapsed_nxt;
         r_max     <= w_max_nxt;
         r_bt      <= w_bt_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

   assign altitude     = r_acc[ALT_W-1:1];
   assign elapsed      = r_elapsed;
   assign max_velocity = r_max;
   assign busy         = (r_state == StRun);
   assign done         = (r_state == StDone);
   assign overflow     = r_ovf;

endmodule

// File: tb/tb_altitude_integrator.sv
// -----------------------------------------------------------------------------
// tb_altitude_integrator
//   Drives two integrators (default width and a narrow 129-bit accumulator)
//   with identical stimulus. Expected results are computed from the closed
//   form of the trapezoidal sum (2*sum(v) - v_last), queued at end of stimulus
//   and compared when done is seen.
// -----------------------------------------------------------------------------
module tb_altitude_integrator;

   localparam int unsigned VEL_W  = 128;
   localparam int unsigned TIME_W = 64;
   localparam int unsigned ALT_A  = 136;
   localparam int unsigned ALT_B  = 129;

   logic              clk;
   logic              resetb;
   logic              start;
   logic [TIME_W-1:0] burntime;
   logic [VEL_W-1:0]  velocity;
   logic              vel_valid;

   logic [ALT_A-2:0]  alt_a;
   logic [TIME_W-1:0] el_a;
   logic [VEL_W-1:0]  mx_a;
   logic              busy_a, done_a, ovf_a;

   logic [ALT_B-2:0]  alt_b;
   logic [TIME_W-1:0] el_b;
   logic [VEL_W-1:0]  mx_b;
   logic              busy_b, done_b, ovf_b;

   altitude_integrator #(
      .VEL_W (VEL_W),
      .TIME_W(TIME_W),
      .ALT_W (ALT_A)
   ) u_dut_a (
      .clk         (clk),
      .resetb      (resetb),
      .start       (start),
      .burntime    (burntime),
      .velocity    (velocity),
      .vel_valid   (vel_valid),
      .altitude    (alt_a),
      .elapsed     (el_a),
      .max_velocity(mx_a),
      .busy        (busy_a),
      .done        (done_a),
      .overflow    (ovf_a)
   );

   altitude_integrator #(
      .VEL_W (VEL_W),
      .TIME_W(TIME_W),
      .ALT_W (ALT_B)
   ) u_dut_b (
      .clk         (clk),
      .resetb      (resetb),
      .start       (start),
      .burntime    (burntime),
      .velocity    (velocity),
      .vel_valid   (vel_valid),
      .altitude    (alt_b),
      .elapsed     (el_b),
      .max_velocity(mx_b),
      .busy        (busy_b),
      .done        (done_b),
      .overflow    (ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ALT_A-2:0]  alt_a;
      logic [ALT_B-2:0]  alt_b;
      logic              ovf_a;
      logic              ovf_b;
      logic [TIME_W-1:0] el;
      logic [VEL_W-1:0]  mx;
   } exp_t;

   exp_t sb_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [159:0]      m_sum;
   logic [VEL_W-1:0]  m_last;
   logic [VEL_W-1:0]  m_max;
   logic [TIME_W-1:0] m_cnt;

   task automatic check_eq(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_sum  = '0;
      m_last = '0;
      m_max  = '0;
      m_cnt  = '0;
   endtask

   // Closed form of the trapezoid sum; saturation is final-value based since
   // the accumulator never decreases.
   task automatic end_run();
      exp_t         e;
      logic [159:0] tot;
      tot = (m_sum << 1) - {32'd0, m_last};
      e.alt_a = (tot[159:ALT_A] != '0) ? '1 : tot[ALT_A-1:1];
      e.ovf_a = (tot[159:ALT_A] != '0);
      e.alt_b = (tot[159:ALT_B] != '0) ? '1 : tot[ALT_B-1:1];
      e.ovf_b = (tot[159:ALT_B] != '0);
      e.el    = m_cnt;
      e.mx    = m_max;
      sb_q.push_back(e);
   endtask

   // All drive tasks are entered and left on a negedge.
   task automatic start_run(input logic [TIME_W-1:0] bt);
      start    = 1'b1;
      burntime = bt;
      @(negedge clk);
      start = 1'b0;
      model_clear();
   endtask

   task automatic drive_sample(input logic [VEL_W-1:0] v);
      vel_valid = 1'b1;
      velocity  = v;
      @(negedge clk);
      vel_valid = 1'b0;
      velocity  = '0;
      m_sum  = m_sum + {32'd0, v};
      m_last = v;
      m_cnt  = m_cnt + 1;
      if (v > m_max) m_max = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input string tag);
      exp_t e;
      int   cyc = 0;
      while (!done_a && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (!done_a) check_eq({tag, "_done_timeout"}, 0, 1);
      if (sb_q.size() == 0) begin
         check_eq({tag, "_sb_underflow"}, 0, 1);
         return;
      end
      e = sb_q.pop_front();
      check_eq({tag, "_done_a"}, done_a, 1);
      check_eq({tag, "_done_b"}, done_b, 1);
      check_eq({tag, "_busy_a"}, busy_a, 0);
      check_eq({tag, "_alt_a"},  alt_a,  e.alt_a);
      check_eq({tag, "_alt_b"},  alt_b,  e.alt_b);
      check_eq({tag, "_ovf_a"},  ovf_a,  e.ovf_a);
      check_eq({tag, "_ovf_b"},  ovf_b,  e.ovf_b);
      check_eq({tag, "_el_a"},   el_a,   e.el);
      check_eq({tag, "_el_b"},   el_b,   e.el);
      check_eq({tag, "_max_a"},  mx_a,   e.mx);
      check_eq({tag, "_max_b"},  mx_b,   e.mx);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_alt_a"},  alt_a,  0);
      check_eq({tag, "_alt_b"},  alt_b,  0);
      check_eq({tag, "_el"},     el_a,   0);
      check_eq({tag, "_max"},    mx_a,   0);
      check_eq({tag, "_busy"},   {busy_a, busy_b}, 0);
      check_eq({tag, "_done"},   {done_a, done_b}, 0);
      check_eq({tag, "_ovf"},    {ovf_a, ovf_b},   0);
   endtask

   initial begin
      logic [VEL_W-1:0] vmax;
      logic [VEL_W-1:0] v;
      int               bt;

      resetb    = 1'b0;
      start     = 1'b0;
      burntime  = '0;
      velocity  = '0;
      vel_valid = 1'b0;
      model_clear();
      idle(3);
      check_zero("reset");
      resetb = 1'b1;
      idle(2);
      check_zero("idle");

      // Reference trapezoid: 1000,2000,3000 -> acc 9000, altitude 4500
      start_run(3);
      check_eq("run_busy", busy_a, 1);
      drive_sample(128'd1000);
      check_eq("run_el1",  el_a, 1);
      check_eq("run_max1", mx_a, 1000);
      check_eq("run_alt1", alt_a, 500);
      drive_sample(128'd2000);
      drive_sample(128'd3000);
      end_run();
      check_eq("t2_alt_const", alt_a, 4500);
      wait_done("t2");

      // Floor rounding: single sample of 3 -> altitude 1
      start_run(1);
      drive_sample(128'd3);
      end_run();
      check_eq("t3_alt_const", alt_a, 1);
      wait_done("t3a");

      // Zero burntime: done immediately after start
      start_run(0);
      end_run();
      check_eq("t3_bt0_done", done_a, 1);
      wait_done("t3b");

      // Gaps and start ignored while running: 10,20 -> altitude 20
      start_run(2);
      idle(5);
      start    = 1'b1;
      burntime = 64'd7;
      @(negedge clk);
      start = 1'b0;
      drive_sample(128'd10);
      idle(5);
      check_eq("t4_busy_gap", busy_a, 1);
      drive_sample(128'd20);
      end_run();
      check_eq("t4_alt_const", alt_a, 20);
      wait_done("t4");

      // Start and sample together in DONE: sample dropped
      start     = 1'b1;
      burntime  = 64'd2;
      vel_valid = 1'b1;
      velocity  = 128'd999;
      @(negedge clk);
      start     = 1'b0;
      vel_valid = 1'b0;
      model_clear();
      check_eq("same_cyc_el", el_a, 0);
      drive_sample(128'd5);
      drive_sample(128'd7);
      end_run();
      wait_done("same_cyc");

      // Saturation on the narrow accumulator, then cleared by the next start
      vmax = '1;
      start_run(2);
      drive_sample(vmax);
      drive_sample(vmax);
      end_run();
      check_eq("t5_ovf_b", ovf_b, 1);
      wait_done("t5");
      start_run(1);
      check_eq("t5_ovf_clr", ovf_b, 0);
      check_eq("t5_el_clr",  el_b, 0);
      drive_sample(128'd4);
      end_run();
      wait_done("t5b");

      // Random wide samples, non-monotone, random gaps
      for (int r = 0; r < 4; r++) begin
         bt = int'($urandom_range(3, 8));
         start_run(TIME_W'(bt));
         for (int s = 0; s < bt; s++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            if (r == 0) v = v >> 70;
            idle(int'($urandom_range(0, 2)));
            drive_sample(v);
         end
         end_run();
         wait_done("rand");
      end

      // Long burn resembling an upstream thrust profile, 168 s
      start_run(168);
      for (int t = 1; t <= 168; t++) begin
         v = VEL_W'(t) * VEL_W'(t) * 128'd50000 + VEL_W'(t) * 128'd123456789;
         idle(int'($urandom_range(0, 2)));
         drive_sample(v);
      end
      end_run();
      wait_done("t6");

      // Reset asserted mid-run aborts everything
      start_run(5);
      drive_sample(128'd111);
      drive_sample(128'd222);
      resetb = 1'b0;
      #1;
      check_zero("midrst_async");
      @(posedge clk);
      #1;
      check_zero("midrst_edge");
      @(negedge clk);
      resetb = 1'b1;
      idle(3);
      check_zero("midrst_after");

      check_eq("sb_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
